neighbor_reader: RTL and testbench

Read-side counterpart to the neighbor-list builder. For a requested 1-indexed vertex, it fetches that vertex's neighbor count and neighbor indices from the neighbor RAM and streams them out over a valid/ready interface. It is used by the downstream subdivision (vertex-update / edge-point) stages, which need each vertex's one-ring. It runs only after the builder has finished (builder busy low) and has exclusive ownership of the neighbor RAM port while busy.

---
 rtl/nbr_pkg.sv | 35 +++
 rtl/neighbor_reader.sv | 205 ++++++++++++++++++++
 tb/tb_neighbor_reader.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/nbr_pkg.sv
// Shared definitions for the neighbor-list builder and reader.
//   ADDR_WIDTH / MAX_NEIGHBOR_COUNT : neighbor RAM geometry (one list per vertex)
//   COUNT_WIDTH                     : width of the stored neighbor count
//   nbr_layout_e                    : word offsets inside one vertex's list
//   nbr_base_addr()                 : first word of a 1-indexed vertex's list
//   nbr_rd_state_e                  : reader FSM states
package nbr_pkg;

  localparam int unsigned ADDR_WIDTH         = 9;
  localparam int unsigned MAX_NEIGHBOR_COUNT = 10;
  localparam int unsigned COUNT_WIDTH        = 4;

  typedef enum logic [ADDR_WIDTH-1:0] {
    COUNT_OFFSET     = ADDR_WIDTH'(0),
    FIRST_NBR_OFFSET = ADDR_WIDTH'(1)
  } nbr_layout_e;

  // Vertices are 1-indexed; the product wraps to the RAM address width.
  function automatic logic [ADDR_WIDTH-1:0] nbr_base_addr(input logic [ADDR_WIDTH-1:0] vertex);
    logic [ADDR_WIDTH-1:0] vm1;
    vm1 = vertex - ADDR_WIDTH'(1);
    return vm1 * ADDR_WIDTH'(MAX_NEIGHBOR_COUNT);
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_RD,
    ST_CNT_CAP,
    ST_NBR_RD,
    ST_NBR_CAP,
    ST_SEND,
    ST_DONE
  } nbr_rd_state_e;

endpackage

// File: rtl/neighbor_reader.sv
// Streams the one-ring of a requested vertex out of the neighbor RAM.
//   req_valid/req_ready/req_vertex : request handshake (1-indexed vertex)
//   vertex_count                   : number of valid vertices, stable while busy
//   RAM_NBR_*                      : read-only use of the neighbor RAM port
//   nbr_valid/nbr_ready/nbr_data/nbr_idx/nbr_last : neighbor beat stream
//   done/rsp_count/err_range/sat   : one-cycle completion status
//   busy                           : request in progress
module neighbor_reader
  import nbr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_vertex,
  input  logic [31:0]            vertex_count,
  output logic                   RAM_NBR_EN,
  output logic [ADDR_WIDTH-1:0]  RAM_NBR_A,
  output logic [3:0]             RAM_NBR_WE,
  output logic [31:0]            RAM_NBR_Di,
  input  logic [31:0]            RAM_NBR_Do,
  output logic                   nbr_valid,
  input  logic                   nbr_ready,
  output logic [31:0]            nbr_data,
  output logic [COUNT_WIDTH-1:0] nbr_idx,
  output logic                   nbr_last,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] rsp_count,
  output logic                   err_range,
  output logic                   sat,
  output logic                   busy
);

  localparam logic [COUNT_WIDTH-1:0] MAX_NBRS = COUNT_WIDTH'(MAX_NEIGHBOR_COUNT - 1);

  nbr_rd_state_e          state_q, state_d;
  logic                   req_ready_q, req_ready_d;
  logic                   busy_q, busy_d;
  logic                   en_q, en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   nbr_valid_q, nbr_valid_d;
  logic [31:0]            nbr_data_q, nbr_data_d;
  logic [COUNT_WIDTH-1:0] nbr_idx_q, nbr_idx_d;
  logic                   nbr_last_q, nbr_last_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] rsp_count_q, rsp_count_d;
  logic                   err_q, err_d;
  logic                   sat_q, sat_d;

  logic [ADDR_WIDTH-1:0]  req_base;
  logic                   req_oor;
  logic [COUNT_WIDTH-1:0] ram_count;

  assign req_base  = nbr_base_addr(req_vertex[ADDR_WIDTH-1:0]);
  assign req_oor   = (req_vertex == '0) || (req_vertex > vertex_count);
  assign ram_count = RAM_NBR_Do[COUNT_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      en_q        <= 1'b0;
      addr_q      <= '0;
      base_q      <= '0;
      count_q     <= '0;
      nbr_valid_q <= 1'b0;
      nbr_data_q  <= '0;
      nbr_idx_q   <= '0;
      nbr_last_q  <= 1'b0;
      done_q      <= 1'b0;
      rsp_count_q <= '0;
      err_q       <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      count_q     <= count_d;
      nbr_valid_q <= nbr_valid_d;
      nbr_data_q  <= nbr_data_d;
      nbr_idx_q   <= nbr_idx_d;
      nbr_last_q  <= nbr_last_d;
      done_q      <= done_d;
      rsp_count_q <= rsp_count_d;
      err_q       <= err_d;
      sat_q       <= sat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    en_d        = en_q;
    addr_d      = addr_q;
    base_d      = base_q;
    count_d     = count_q;
    nbr_valid_d = nbr_valid_q;
    nbr_data_d  = nbr_data_q;
    nbr_idx_d   = nbr_idx_q;
    nbr_last_d  = nbr_last_q;
    done_d      = 1'b0;
    rsp_count_d = rsp_count_q;
    err_d       = err_q;
    sat_d       = sat_q;

    unique case (state_q)
      ST_IDLE: begin
        // err/sat stay visible through the done cycle, then clear here.
        req_ready_d = 1'b1;
        err_d       = 1'b0;
        sat_d       = 1'b0;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          base_d      = req_base;
          if (req_oor) begin
            err_d       = 1'b1;
            rsp_count_d = '0;
            state_d     = ST_DONE;
          end else begin
            en_d    = 1'b1;
            addr_d  = req_base + COUNT_OFFSET;
            state_d = ST_CNT_RD;
          end
        end
      end

      ST_CNT_RD: state_d = ST_CNT_CAP;

      ST_CNT_CAP: begin
        if (ram_count > MAX_NBRS) begin
          count_d = MAX_NBRS;
          sat_d   = 1'b1;
        end else begin
          count_d = ram_count;
        end
        if (ram_count == '0) begin
          rsp_count_d = '0;
          state_d     = ST_DONE;
        end else begin
          addr_d    = base_q + FIRST_NBR_OFFSET;
          nbr_idx_d = '0;
          state_d   = ST_NBR_RD;
        end
      end

      ST_NBR_RD: state_d = ST_NBR_CAP;

      ST_NBR_CAP: begin
        nbr_data_d  = RAM_NBR_Do;
        nbr_valid_d = 1'b1;
        nbr_last_d  = (nbr_idx_q == count_q - COUNT_WIDTH'(1));
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        if (nbr_ready) begin
          nbr_valid_d = 1'b0;
          if (nbr_last_q) begin
            nbr_last_d  = 1'b0;
            rsp_count_d = count_q;
            state_d     = ST_DONE;
          end else begin
            nbr_idx_d = nbr_idx_q + COUNT_WIDTH'(1);
            addr_d    = base_q + ADDR_WIDTH'(nbr_idx_q) + ADDR_WIDTH'(2);
            state_d   = ST_NBR_RD;
          end
        end
      end

      ST_DONE: begin
        done_d      = 1'b1;
        en_d        = 1'b0;
        busy_d      = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign RAM_NBR_EN = en_q;
  assign RAM_NBR_A  = addr_q;
  assign RAM_NBR_WE = 4'b0000;
  assign RAM_NBR_Di = '0;
  assign nbr_valid  = nbr_valid_q;
  assign nbr_data   = nbr_data_q;
  assign nbr_idx    = nbr_idx_q;
  assign nbr_last   = nbr_last_q;
  assign done       = done_q;
  assign rsp_count  = rsp_count_q;
  assign err_range  = err_q;
  assign sat        = sat_q;

endmodule

// File: tb/tb_neighbor_reader.sv
module tb_neighbor_reader;
  import nbr_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_vertex = '0;
  logic [31:0] vertex_count = 32'd5;
  logic        RAM_NBR_EN;
  logic [ADDR_WIDTH-1:0] RAM_NBR_A;
  logic [3:0]  RAM_NBR_WE;
  logic [31:0] RAM_NBR_Di;
  logic [31:0] RAM_NBR_Do;
  logic        nbr_valid;
  logic        nbr_ready = 1'b1;
  logic [31:0] nbr_data;
  logic [3:0]  nbr_idx;
  logic        nbr_last;
  logic        done;
  logic [3:0]  rsp_count;
  logic        err_range;
  logic        sat;
  logic        busy;

  neighbor_reader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vertex(req_vertex),
    .vertex_count(vertex_count),
    .RAM_NBR_EN(RAM_NBR_EN), .RAM_NBR_A(RAM_NBR_A), .RAM_NBR_WE(RAM_NBR_WE),
    .RAM_NBR_Di(RAM_NBR_Di), .RAM_NBR_Do(RAM_NBR_Do),
    .nbr_valid(nbr_valid), .nbr_ready(nbr_ready), .nbr_data(nbr_data),
    .nbr_idx(nbr_idx), .nbr_last(nbr_last),
    .done(done), .rsp_count(rsp_count), .err_range(err_range), .sat(sat),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM: address sampled at the edge, data valid next cycle.
  logic [31:0] mem [0:511];
  logic [31:0] rdata = '0;
  always @(posedge clk) if (RAM_NBR_EN) rdata <= mem[RAM_NBR_A];
  assign RAM_NBR_Do = rdata;

  typedef struct { logic [31:0] data; logic [3:0] idx; logic last; } beat_t;
  typedef struct { logic [3:0] cnt; logic err; logic sat; } dn_t;
  beat_t beat_q[$];
  dn_t   done_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int first_valid_cyc = -1;
  bit en_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat or a done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (RAM_NBR_EN) en_seen = 1;
      if (nbr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (nbr_valid && nbr_ready) begin
        if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_data", nbr_data, b.data);
          chk("beat_idx", 32'(nbr_idx), 32'(b.idx));
          chk("beat_last", 32'(nbr_last), 32'(b.last));
        end
      end
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          dn_t d;
          d = done_q.pop_front();
          chk("rsp_count", 32'(rsp_count), 32'(d.cnt));
          chk("err_range", 32'(err_range), 32'(d.err));
          chk("sat", 32'(sat), 32'(d.sat));
          chk("ram_we_zero", 32'(RAM_NBR_WE), 0);
        end
      end
    end
  end

  task automatic push_beat(input logic [31:0] d, input logic [3:0] i, input logic l);
    beat_t b;
    b.data = d; b.idx = i; b.last = l;
    beat_q.push_back(b);
  endtask

  task automatic push_done(input logic [3:0] c, input logic e, input logic s);
    dn_t d;
    d.cnt = c; d.err = e; d.sat = s;
    done_q.push_back(d);
  endtask

  task automatic issue(input int v);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    req_valid = 1'b1;
    req_vertex = v;
    first_valid_cyc = -1;
    en_seen = 0;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge clk); n++; end
    if (done_cnt == d0) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!nbr_valid && n < 50) begin @(negedge clk); n++; end
    if (!nbr_valid) chk("valid_timeout", 0, 1);
  endtask

  initial begin
    int d0;
    logic [31:0] sd;
    logic [3:0]  si;
    logic [ADDR_WIDTH-1:0] sa;

    for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD0000 + i;
    mem[0]  = 32'd0;                                   // vertex 1: no neighbors
    mem[10] = 32'd3; mem[11] = 32'd1; mem[12] = 32'd3; mem[13] = 32'd5;  // vertex 2
    mem[20] = 32'd12;                                  // vertex 3: clamped to 9
    for (int i = 1; i <= 9; i++) mem[20+i] = 32'd100 + i;

    #12;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_nbr_valid", 32'(nbr_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ram_en", 32'(RAM_NBR_EN), 0);
    chk("rst_ram_a", 32'(RAM_NBR_A), 0);
    chk("rst_rsp_count", 32'(rsp_count), 0);
    rst_n = 1'b1;

    // Vertex 2: three neighbors, consumer always ready.
    push_beat(1, 0, 0); push_beat(3, 1, 0); push_beat(5, 2, 1); push_done(3, 0, 0);
    d0 = done_cnt; issue(2); wait_done(d0);
    chk("v2_first_valid_lat", first_valid_cyc - acc_cyc, 4);

    // Vertex 1: zero neighbors.
    push_done(0, 0, 0);
    d0 = done_cnt; issue(1); wait_done(d0);
    chk("v1_done_lat", done_cyc - acc_cyc, 3);
    chk("v1_no_valid", first_valid_cyc, -1);

    // Out of range: vertex 0 and vertex_count+1.
    push_done(0, 1, 0);
    d0 = done_cnt; issue(0); wait_done(d0);
    chk("v0_done_lat", done_cyc - acc_cyc, 1);
    chk("v0_no_ram_en", 32'(en_seen), 0);
    push_done(0, 1, 0);
    d0 = done_cnt; issue(6); wait_done(d0);
    chk("v6_done_lat", done_cyc - acc_cyc, 1);
    chk("v6_no_ram_en", 32'(en_seen), 0);

    // Vertex 3: stored count 12 saturates to 9.
    for (int i = 0; i < 9; i++) push_beat(32'd101 + i, 4'(i), i == 8);
    push_done(9, 0, 1);
    d0 = done_cnt; issue(3); wait_done(d0);

    // Backpressure on the first beat plus an ignored mid-stream request.
    nbr_ready = 1'b0;
    push_beat(1, 0, 0); push_beat(3, 1, 0); push_beat(5, 2, 1); push_done(3, 0, 0);
    d0 = done_cnt; issue(2); wait_valid();
    sd = nbr_data; si = nbr_idx; sa = RAM_NBR_A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(nbr_valid), 1);
      chk("stall_data", nbr_data, sd);
      chk("stall_idx", 32'(nbr_idx), 32'(si));
      chk("stall_addr", 32'(RAM_NBR_A), 32'(sa));
      if (i == 1) begin req_valid = 1'b1; req_vertex = 3; end
      if (i == 2) begin chk("stall_req_ready", 32'(req_ready), 0); req_valid = 1'b0; end
    end
    nbr_ready = 1'b1;
    wait_done(d0);

    // Reset asserted while a beat is waiting in SEND.
    nbr_ready = 1'b0;
    issue(3); wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(nbr_valid), 0);
    chk("mid_rst_req_ready", 32'(req_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ram_en", 32'(RAM_NBR_EN), 0);
    chk("mid_rst_ram_a", 32'(RAM_NBR_A), 0);
    chk("mid_rst_data", nbr_data, 0);
    chk("mid_rst_idx", 32'(nbr_idx), 0);
    chk("mid_rst_sat", 32'(sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nbr_ready = 1'b1;
    push_beat(1, 0, 0); push_beat(3, 1, 0); push_beat(5, 2, 1); push_done(3, 0, 0);
    d0 = done_cnt; issue(2); wait_done(d0);

    repeat (5) @(negedge clk);
    chk("beats_left", beat_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
